// File: rtl/hazard_control_unit.sv
// Hazard controller for an N-stage in-order pipeline: merges stall requests and
// prioritised redirects into per-register stall/flush controls, with perf counters and a stall watchdog.
module hazard_control_unit #(
  parameter int NUM_STAGES   = 5,
  parameter int NUM_REDIRECT = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int WDOG_CYCLES  = 1024,
  localparam int STG_W       = $clog2(NUM_STAGES),
  localparam int SEL_W       = $clog2(NUM_STAGES + NUM_REDIRECT + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_STAGES-1:0]              stage_stall_req,
  input  logic [NUM_REDIRECT-1:0]            redirect_valid,
  input  logic [NUM_REDIRECT*STG_W-1:0]      redirect_stage,
  input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_target,
  output logic [NUM_REDIRECT-1:0]            redirect_ready,
  output logic [NUM_STAGES-1:0]              reg_stall,
  output logic [NUM_STAGES-1:0]              reg_flush,
  output logic                               load_pc_we,
  output logic [ADDR_WIDTH-1:0]              load_pc_new_pc,
  input  logic [SEL_W-1:0]                   perf_sel,
  input  logic                               perf_clear,
  output logic [CNT_WIDTH-1:0]               perf_data,
  output logic                               hang
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [NUM_STAGES-1:0]   stall_chain_s;
  logic                    chain_acc_s;
  logic [NUM_REDIRECT-1:0] stage_ok_s;
  logic                    take_s;
  logic                    win_found_s;
  logic [STG_W-1:0]        win_stage_s;
  logic [NUM_REDIRECT-1:0] win_onehot_s;
  logic [ADDR_WIDTH-1:0]   win_target_s;
  logic [NUM_STAGES-1:0]   redir_mask_s;
  logic [NUM_STAGES-1:0]   base_flush_s;
  logic                    wdog_inc_s;
  logic [CNT_WIDTH-1:0]    perf_mux_s;

  logic [CNT_WIDTH-1:0] stall_cnt_q [NUM_STAGES];
  logic [CNT_WIDTH-1:0] stall_cnt_d [NUM_STAGES];
  logic [CNT_WIDTH-1:0] redir_cnt_q [NUM_REDIRECT];
  logic [CNT_WIDTH-1:0] redir_cnt_d [NUM_REDIRECT];
  logic [CNT_WIDTH-1:0] wdog_cnt_q, wdog_cnt_d;
  logic                 hang_q, hang_d;
  logic [CNT_WIDTH-1:0] perf_data_q, perf_data_d;

  // stall_chain[k]: some stage at or downstream of k (excluding WB) is stalled
  always_comb begin
    stall_chain_s = '0;
    chain_acc_s   = 1'b0;
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      chain_acc_s      = chain_acc_s | stage_stall_req[k];
      stall_chain_s[k] = chain_acc_s;
    end
  end

  // A source is blockable only by stalls at or below its own stage
  always_comb begin
    stage_ok_s = '0;
    for (int r = 0; r < NUM_REDIRECT; r++) begin
      if (int'(redirect_stage[r*STG_W +: STG_W]) < NUM_STAGES) begin
        stage_ok_s[r] = ~stall_chain_s[redirect_stage[r*STG_W +: STG_W]];
      end else begin
        stage_ok_s[r] = 1'b0;
      end
    end
  end

  // Strict '>' keeps the lowest index on equal stages
  always_comb begin
    take_s       = 1'b0;
    win_found_s  = 1'b0;
    win_stage_s  = '0;
    win_onehot_s = '0;
    win_target_s = redirect_target[ADDR_WIDTH-1:0];
    for (int r = 0; r < NUM_REDIRECT; r++) begin
      take_s = redirect_valid[r] & stage_ok_s[r] &
               (~win_found_s | (redirect_stage[r*STG_W +: STG_W] > win_stage_s));
      win_found_s  = win_found_s | take_s;
      win_stage_s  = take_s ? redirect_stage[r*STG_W +: STG_W] : win_stage_s;
      win_onehot_s = take_s ? (NUM_REDIRECT'(1) << r) : win_onehot_s;
      win_target_s = take_s ? redirect_target[r*ADDR_WIDTH +: ADDR_WIDTH] : win_target_s;
    end
  end

  // Per-register masks: bubble behind a stalled stage, redirect span 0..winner stage
  always_comb begin
    base_flush_s = '0;
    redir_mask_s = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      redir_mask_s[k] = win_found_s & ~rst & (k <= int'(win_stage_s));
      if (k > 0) begin
        base_flush_s[k] = stage_stall_req[k-1] & ~stall_chain_s[k];
      end else begin
        base_flush_s[k] = 1'b0;
      end
    end
  end

  // Pipeline controls, overridden while in reset
  always_comb begin
    reg_stall      = '0;
    reg_flush      = '0;
    load_pc_we     = 1'b0;
    load_pc_new_pc = redirect_target[ADDR_WIDTH-1:0];
    redirect_ready = '0;
    if (rst) begin
      reg_flush = {{(NUM_STAGES-1){1'b1}}, 1'b0};
    end else begin
      reg_stall      = stall_chain_s & ~redir_mask_s;
      reg_flush      = base_flush_s | (redir_mask_s & {{(NUM_STAGES-1){1'b1}}, 1'b0});
      load_pc_we     = win_found_s;
      load_pc_new_pc = win_found_s ? win_target_s : redirect_target[ADDR_WIDTH-1:0];
      redirect_ready = win_onehot_s;
    end
  end

  // Counter readout mux over the current (pre-edge) counter values
  always_comb begin
    perf_mux_s = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      perf_mux_s = (perf_sel == SEL_W'(s)) ? stall_cnt_q[s] : perf_mux_s;
    end
    for (int r = 0; r < NUM_REDIRECT; r++) begin
      perf_mux_s = (perf_sel == SEL_W'(NUM_STAGES + r)) ? redir_cnt_q[r] : perf_mux_s;
    end
    perf_mux_s = (perf_sel == SEL_W'(NUM_STAGES + NUM_REDIRECT)) ? wdog_cnt_q : perf_mux_s;
  end

  // Counter, watchdog and readout next state; perf_clear beats increments
  always_comb begin
    wdog_inc_s = (|stage_stall_req[NUM_STAGES-2:0]) & ~load_pc_we;
    for (int s = 0; s < NUM_STAGES; s++) begin
      stall_cnt_d[s] = perf_clear ? '0 :
                       (stage_stall_req[s] ? sat_inc(stall_cnt_q[s]) : stall_cnt_q[s]);
    end
    for (int r = 0; r < NUM_REDIRECT; r++) begin
      redir_cnt_d[r] = perf_clear ? '0 :
                       (redirect_ready[r] ? sat_inc(redir_cnt_q[r]) : redir_cnt_q[r]);
    end
    wdog_cnt_d  = perf_clear ? '0 : (wdog_inc_s ? sat_inc(wdog_cnt_q) : '0);
    hang_d      = perf_clear ? 1'b0 :
                  (hang_q | (wdog_inc_s & (wdog_cnt_q == CNT_WIDTH'(WDOG_CYCLES - 1))));
    perf_data_d = perf_mux_s;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) stall_cnt_q[s] <= '0;
      for (int r = 0; r < NUM_REDIRECT; r++) redir_cnt_q[r] <= '0;
      wdog_cnt_q  <= '0;
      hang_q      <= 1'b0;
      perf_data_q <= '0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) stall_cnt_q[s] <= stall_cnt_d[s];
      for (int r = 0; r < NUM_REDIRECT; r++) redir_cnt_q[r] <= redir_cnt_d[r];
      wdog_cnt_q  <= wdog_cnt_d;
      hang_q      <= hang_d;
      perf_data_q <= perf_data_d;
    end
  end

  assign perf_data = perf_data_q;
  assign hang      = hang_q;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised hazard controller for an N-stage in-order pipeline. It merges per-stage stall requests and multi-source control-flow redirects into stall/flush controls for every pipeline register, plus the PC load, with a same-cycle priority rule. It also keeps saturating per-stage stall and per-source redirect counters and a stall watchdog that flags a hung pipeline. It sits beside the datapath where the fixed five-stage hazard logic sits today.

## Interface
- NUM_STAGES, 5: pipeline stages; stage 0 = IF, stage NUM_STAGES-1 = WB.
- NUM_REDIRECT, 2: number of redirect sources.
- ADDR_WIDTH, 32: PC width.
- CNT_WIDTH, 32: perf counter width.
- WDOG_CYCLES, 1024: consecutive stalled cycles before `hang` is raised.
- Derived: STG_W = $clog2(NUM_STAGES); SEL_W = $clog2(NUM_STAGES+NUM_REDIRECT+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stage_stall_req  in  NUM_STAGES  bit s: stage s cannot advance this cycle. Bit NUM_STAGES-1 is ignored.
- redirect_valid  in  NUM_REDIRECT  bit r: source r requests a PC redirect.
- redirect_stage  in  NUM_REDIRECT*STG_W  stage that raised source r. Range is 1..NUM_STAGES-2.
- redirect_target  in  NUM_REDIRECT*ADDR_WIDTH  new PC for source r.
- redirect_ready  out  NUM_REDIRECT  one-hot: source r was accepted this cycle.
- reg_stall  out  NUM_STAGES  bit k: hold the register feeding stage k. Register 0 is the PC.
- reg_flush  out  NUM_STAGES  bit k: load a bubble into the register feeding stage k.
- load_pc_we  out  1  load the PC register.
- load_pc_new_pc  out  ADDR_WIDTH  value to load.
- perf_sel  in  SEL_W  counter select.
- perf_clear  in  1  clear all counters and `hang`.
- perf_data  out  CNT_WIDTH  registered counter readout.
- hang  out  1  sticky watchdog flag.

## Operation
- stall_chain[k] = OR of stage_stall_req[j] for k ≤ j ≤ NUM_STAGES-2.
- Base controls:
  - reg_stall[k] = stall_chain[k].
  - reg_flush[k] = 1 when stage_stall_req[k-1] is set and stall_chain[k] is 0. This inserts a bubble behind the stalled stage.
  - reg_flush[0] = 0 and reg_stall[NUM_STAGES-1] = 0 always.
- Redirect arbitration:
  - Eligible sources are those with valid set and stall_chain[stage] = 0.
  - Among eligible sources, the highest stage wins. Ties go to the lowest r.
  - Non-winners and blocked sources see ready = 0 and must hold their request.
- Accepted redirect from stage s:
  - load_pc_we = 1 and load_pc_new_pc = the winner's target.
  - reg_flush[1..s] = 1, ORed with the base flushes.
  - reg_stall[0..s] is forced to 0.
  - redirect_ready is set for the winner only.
- With no accepted redirect, load_pc_we = 0 and load_pc_new_pc = target of source 0.
- Counters, saturating at all-ones:
  - stall_cnt[s] increments on each cycle stage_stall_req[s] is set.
  - redir_cnt[r] increments on each cycle redirect_ready[r] is set.
  - wdog_cnt increments while any stage_stall_req[NUM_STAGES-2:0] is set and no redirect is accepted. It returns to 0 otherwise.
- Watchdog: `hang` sets when wdog_cnt reaches WDOG_CYCLES-1 and the increment condition holds. It stays set until rst or perf_clear.
- perf_sel map:
  - 0..NUM_STAGES-1: stall_cnt.
  - next NUM_REDIRECT values: redir_cnt.
  - next value: wdog_cnt.
  - anything else reads 0.
- perf_clear zeroes all counters and `hang` at the next edge and has priority over increments.

## Timing
- reg_stall, reg_flush, load_pc_*, redirect_ready: combinational from the same-cycle inputs, zero latency.
- Counters, `hang`, perf_data: update at posedge clk. perf_data reflects perf_sel from the previous cycle.
- While rst is high:
  - reg_flush = all ones except bit 0; reg_stall = 0.
  - load_pc_we = 0; redirect_ready = 0.
  - At the edge, counters, `hang` and perf_data become 0.
- Reset asserted mid-stall or mid-redirect discards all state. No redirect is remembered.

## Test plan
- NUM_STAGES=5, stage_stall_req=5'b01000 -> reg_stall=5'b01111, reg_flush=5'b10000, load_pc_we=0.
- stage_stall_req=5'b00010 -> reg_stall=5'b00011, reg_flush=5'b00100.
- Redirect conflict:
  - Stimulus: src0 at stage 1 with target 0x100, and src1 at stage 2 with target 0x200, in the same cycle; stage_stall_req=5'b00001.
  - Required: redirect_ready=2'b10, load_pc_new_pc=0x200, reg_flush=5'b00110, reg_stall=5'b00000.
- Src1 at stage 2 while stage_stall_req=5'b01000 -> redirect_ready=0, load_pc_we=0, reg_stall=5'b01111. After the stall drops, accepted the same cycle.
- Watchdog with WDOG_CYCLES=8:
  - Hold stage_stall_req[3] -> `hang` rises after the 8th edge.
  - Drop the stall -> `hang` stays 1.
  - perf_clear -> `hang`=0 and wdog_cnt=0.
- Counters with CNT_WIDTH=4:
  - Stall stage 0 for 3 cycles, then perf_sel=0 -> perf_data=3 one cycle later.
  - Stall stage 0 for 20 cycles -> perf_data=15, saturated.
